// File: rtl/divu_4bit_seq.sv
// divu_4bit_seq: restoring sequential divider, one quotient bit per clock; define DIV_SIGNED_EN for signed mode
module divu_4bit_seq #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             sgn,
    output logic [WIDTH-1:0] quot,
    output logic [WIDTH-1:0] rem,
    output logic             busy,
    output logic             done,
    output logic             divz,
    output logic             ovfl
);
    localparam int CW = $clog2(WIDTH + 1);
    typedef enum logic [1:0] {IDLE, CALC, FIN} state_t;
    state_t state;
    logic [WIDTH-1:0] p, q, bb, ma, mb, pn, qn, qf, rf;
    logic [CW-1:0] cnt;
    logic [WIDTH:0] sh;
    logic [WIDTH+1:0] s;
    logic se, sg, nq, nr, unused;
`ifdef DIV_SIGNED_EN
    assign se = sgn;
    assign unused = s[WIDTH];
`else
    assign se = 1'b0;
    assign unused = s[WIDTH] ^ sgn;
`endif
    assign ma = (se && A[WIDTH-1]) ? -A : A;
    assign mb = (se && B[WIDTH-1]) ? -B : B;
    assign sh = {p, q[WIDTH-1]};
    assign s = {1'b0, sh} + {2'b01, ~bb} + (WIDTH+2)'(1);
    assign pn = s[WIDTH+1] ? s[WIDTH-1:0] : sh[WIDTH-1:0];
    assign qn = {q[WIDTH-2:0], s[WIDTH+1]};
    assign qf = nq ? -qn : qn;
    assign rf = nr ? -pn : pn;
    // control FSM with trial-subtract datapath and registered results
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            p <= '0;
            q <= '0;
            bb <= '0;
            cnt <= '0;
            sg <= 1'b0;
            nq <= 1'b0;
            nr <= 1'b0;
            quot <= '0;
            rem <= '0;
            busy <= 1'b0;
            done <= 1'b0;
            divz <= 1'b0;
            ovfl <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        busy <= 1'b1;
                        divz <= (B == '0);
                        ovfl <= 1'b0;
                        bb <= mb;
                        p <= '0;
                        q <= ma;
                        cnt <= CW'(WIDTH - 1);
                        sg <= se;
                        nq <= se && (A[WIDTH-1] ^ B[WIDTH-1]);
                        nr <= se && A[WIDTH-1];
                        if (B == '0) begin
                            state <= FIN;
                            quot <= '1;
                            rem <= A;
                        end else begin
                            state <= CALC;
                        end
                    end
                end
                CALC: begin
                    p <= pn;
                    q <= qn;
                    cnt <= cnt - CW'(1);
                    if (cnt == '0) begin
                        state <= FIN;
                        done <= 1'b1;
                        quot <= qf;
                        rem <= rf;
                        ovfl <= sg && !nq && qn[WIDTH-1];
                    end
                end
                FIN: begin
                    if (done) begin
                        done <= 1'b0;
                        busy <= 1'b0;
                        state <= IDLE;
                    end else begin
                        done <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
